// File: rtl/tr_alu_exec.sv
// Time-redundant execute-stage ALU: one combinational core reused over successive
// passes, duplex compare with a third-pass majority vote and bounded full retries.
module tr_alu_exec #(
    parameter int WIDTH      = 32,
    parameter int TMR_ALWAYS = 0,
    parameter int MAX_RETRY  = 1,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             inj_en,
    input  logic [2:0]       inj_pass,
    input  logic [WIDTH-1:0] inj_mask,
    input  logic             cnt_clr,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             corrected,
    output logic             uncorrectable,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [2:0] MAX_R = 3'(MAX_RETRY);

    typedef enum logic [1:0] {IDLE, T1, T2, T3} state_t;

    state_t           state;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] res_t1;
    logic [WIDTH-1:0] res_t2;
    logic [2:0]       retry;

    logic [WIDTH-1:0] core;
    logic [WIDTH-1:0] rot_mask;
    logic             inj_sel;
    logic [WIDTH-1:0] pass_val;
    logic             agree_13;
    logic             agree_23;
    logic             agree_12;
    logic             commit;
    logic             commit_corr;
    logic             commit_unc;
    logic             do_retry;
    logic [WIDTH-1:0] commit_word;

    assign busy = (state != IDLE);

    always_comb begin
        core = '0;
        case (op_r)
            3'b000:  core = a_r + b_r;
            3'b001:  core = a_r - b_r;
            3'b010:  core = a_r & b_r;
            3'b011:  core = a_r | b_r;
            3'b100:  core = a_r ^ b_r;
            3'b101:  core = {{(WIDTH-1){1'b0}}, ($signed(a_r) < $signed(b_r))};
            3'b110:  core = a_r << b_r[SHW-1:0];
            default: core = a_r >> b_r[SHW-1:0];
        endcase
    end

    // Pass p flips the core output with the mask rotated left by p-1.
    always_comb begin
        rot_mask = inj_mask;
        inj_sel  = 1'b0;
        case (state)
            T1: begin
                rot_mask = inj_mask;
                inj_sel  = inj_pass[0];
            end
            T2: begin
                rot_mask = {inj_mask[WIDTH-2:0], inj_mask[WIDTH-1]};
                inj_sel  = inj_pass[1];
            end
            T3: begin
                rot_mask = {inj_mask[WIDTH-3:0], inj_mask[WIDTH-1:WIDTH-2]};
                inj_sel  = inj_pass[2];
            end
            default: begin
                rot_mask = inj_mask;
                inj_sel  = 1'b0;
            end
        endcase
        pass_val = core ^ ((inj_en && inj_sel) ? rot_mask : '0);
    end

    assign agree_13 = (pass_val == res_t1);
    assign agree_23 = (pass_val == res_t2);
    assign agree_12 = (res_t1 == res_t2);

    always_comb begin
        commit      = 1'b0;
        commit_corr = 1'b0;
        commit_unc  = 1'b0;
        do_retry    = 1'b0;
        commit_word = pass_val;
        case (state)
            T2: begin
                if (TMR_ALWAYS == 0 && pass_val == res_t1) begin
                    commit      = 1'b1;
                    commit_word = res_t1;
                end
            end
            T3: begin
                if (agree_13 || agree_23 || agree_12) begin
                    commit      = 1'b1;
                    commit_word = (agree_13 || agree_12) ? res_t1 : res_t2;
                    commit_corr = !(agree_12 && agree_13);
                end else if (retry < MAX_R) begin
                    do_retry = 1'b1;
                end else begin
                    commit      = 1'b1;
                    commit_word = pass_val;
                    commit_unc  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            op_r          <= '0;
            a_r           <= '0;
            b_r           <= '0;
            res_t1        <= '0;
            res_t2        <= '0;
            retry         <= '0;
            done          <= 1'b0;
            result        <= '0;
            corrected     <= 1'b0;
            uncorrectable <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_r  <= alu_op;
                        a_r   <= a;
                        b_r   <= b;
                        retry <= '0;
                        state <= T1;
                    end
                end
                T1: begin
                    res_t1 <= pass_val;
                    state  <= T2;
                end
                T2: begin
                    res_t2 <= pass_val;
                    state  <= commit ? IDLE : T3;
                end
                T3: begin
                    if (do_retry) begin
                        retry <= retry + 3'd1;
                        state <= T1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (commit) begin
                done          <= 1'b1;
                result        <= commit_word;
                corrected     <= commit_corr;
                uncorrectable <= commit_unc;
            end
        end
    end

    // A clear in the same cycle as a counted commit leaves the counter at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (cnt_clr) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else begin
            if (commit && commit_corr && corr_cnt != '1)
                corr_cnt <= corr_cnt + CNT_W'(1);
            if (commit && commit_unc && uncorr_cnt != '1)
                uncorr_cnt <= uncorr_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/tr_alu_exec.md
# tr_alu_exec

Parametrised time-redundant ALU for the execute stage of the RV32 pipeline. Each accepted operation runs on a single combinational ALU core over successive cycles. In duplex mode, two passes that agree commit immediately. A mismatch triggers a third pass with a word-level majority vote, then bounded full retries. The block drives a stall request to the hazard unit, provides error counters, and has a built-in fault-injection port so benches need no hierarchical `force`.

## Interface
- WIDTH, 32: datapath width, minimum 8; SHW = clog2(WIDTH).
- TMR_ALWAYS, 0: 0 = duplex with tie-break; 1 = always run three passes and vote.
- MAX_RETRY, 1: number of full re-executions allowed after a failed vote (0..7).
- CNT_W, 8: width of the saturating error counters.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  operation request; sampled only in IDLE
- alu_op  in  3  operation select: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT (signed), 110 SLL, 111 SRL
- a, b  in  WIDTH  operands
- inj_en  in  1  enable fault injection
- inj_pass  in  3  bit p-1 selects injection on pass p
- inj_mask  in  WIDTH  XOR mask; on pass p it is rotated left by p-1
- cnt_clr  in  1  synchronous clear of both counters
- busy  out  1  state != IDLE; drives the stall request
- done  out  1  one-cycle pulse when result is valid
- result  out  WIDTH  committed result; held until the next done
- corrected  out  1  valid with done; fault masked by vote
- uncorrectable  out  1  valid with done; retries exhausted
- corr_cnt, uncorr_cnt  out  CNT_W  saturating event counts

## Operation
- States: IDLE, T1, T2, T3.
- IDLE, start=1: latch alu_op, a and b; clear the retry count; go to T1. Later operand changes are ignored until the next IDLE.
- T1: res_t1 <= core ^ inj. Go to T2.
- T2: res_t2 <= core ^ inj.
  - If TMR_ALWAYS=0 and the core result equals res_t1: commit res_t1 with corrected=0 and return to IDLE.
  - Otherwise go to T3.
- T3: t3 = core ^ inj.
  - If t3 equals res_t1 or res_t2, or res_t1 equals res_t2: commit the majority word. Set corrected=1 if any of the three differed.
  - Otherwise, if retry < MAX_RETRY: increment retry and go to T1.
  - Otherwise: commit t3 with uncorrectable=1.
  - Return to IDLE on any commit.
- inj = inj_en && inj_pass[p-1] ? rotl(inj_mask, p-1) : 0. Injection applies on every attempt.
- Arithmetic:
  - ADD/SUB are modulo 2^WIDTH.
  - SLT returns 1 or 0, zero-extended.
  - Shift amount is b[SHW-1:0]; SRL is logical.
- Counters:
  - Increment on a done carrying corrected or uncorrectable, saturating at all-ones.
  - cnt_clr wins over a same-cycle increment.

## Timing
- Reset values: state IDLE; busy 0, done 0, result 0, corrected 0, uncorrectable 0, both counters 0, internal registers 0.
- E0 is the edge sampling start.
  - Duplex agreement: done is set at E2.
  - Vote (or TMR_ALWAYS=1): done is set at E3.
  - Each retry adds 3 edges; the uncorrectable case with MAX_RETRY=1 sets done at E6.
- busy rises at E0 and falls at the committing edge, so busy=0 in the same cycle done=1.
- A new start is accepted in the done cycle. Back-to-back throughput is therefore 1 operation per 3 cycles in duplex mode.
- start while busy is ignored; it is neither queued nor counted.
- rst mid-operation: immediate return to IDLE with all outputs 0 and no done pulse.
- corrected, uncorrectable and result update only on done; they are held otherwise.

## Test plan
- Clean duplex: a=10, b=8, ADD, TMR_ALWAYS=0 -> done at E2, result=18, corrected=0, counters 0.
- Transient on pass 2: inj_pass=010, inj_mask=0xFFFFFFFF, same ADD -> done at E3, result=18, corrected=1, corr_cnt=1.
- Uncorrectable: inj_pass=111, inj_mask=1, ADD 10+8. Pass values are 19, 16 and 22 on both attempts -> done at E6, uncorrectable=1, result=22, uncorr_cnt=1.
- Operation coverage:
  - SUB 5-7 -> 0xFFFFFFFE.
  - SLT a=-1, b=1 -> 1.
  - SLL 1 by b=33 -> 2 (shift uses b[4:0]).
  - TMR_ALWAYS=1 -> every done at E3 with corrected=0.
- Robustness:
  - Pulse start while busy with different operands -> first result unchanged, exactly one done.
  - Assert rst at T2 -> no done; busy=0 immediately.
- Counters with CNT_W=2: five corrected operations -> corr_cnt saturates at 3. cnt_clr coincident with a corrected done -> corr_cnt=0.
